// File: rtl/led_matrix_column_scanner_if.sv
// Signal bundle between the image decoders and the LED matrix column scanner.
// The blink request only exists when LED_MATRIX_SCAN_BLINK_EN is defined.
interface led_matrix_column_scanner_if;
  logic       enable;
  logic [6:0] col_2_in;
  logic [6:0] col_1_in;
  logic [6:0] col_0_in;
  logic [4:0] column_n;
  logic [6:0] row;
  logic       frame_start;
`ifdef LED_MATRIX_SCAN_BLINK_EN
  logic       blink;

  modport master (
    output enable, col_2_in, col_1_in, col_0_in, blink,
    input  column_n, row, frame_start
  );
  modport slave (
    input  enable, col_2_in, col_1_in, col_0_in, blink,
    output column_n, row, frame_start
  );
`else
  modport master (
    output enable, col_2_in, col_1_in, col_0_in,
    input  column_n, row, frame_start
  );
  modport slave (
    input  enable, col_2_in, col_1_in, col_0_in,
    output column_n, row, frame_start
  );
`endif
endinterface

// File: rtl/led_matrix_column_scanner.sv
// Scans three mirrored column images onto a 5x7 LED matrix, one column per DIV-cycle slot.
// Optional blinking is compiled in with LED_MATRIX_SCAN_BLINK_EN.
module led_matrix_column_scanner #(
  parameter int DIV          = 1000,
  parameter int BLANK        = 1,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                         clock,
  input  logic                         reset_n,
  led_matrix_column_scanner_if.slave   bus
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  // An illegal configuration keeps the matrix dark rather than scanning garbage.
  localparam bit            CFG_OK   = (DIV >= 2) && (BLANK >= 0) && (BLANK < DIV) && (BLINK_FRAMES >= 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    shadow_2_q, shadow_2_d;
  logic [6:0]    shadow_1_q, shadow_1_d;
  logic [6:0]    shadow_0_q, shadow_0_d;
  logic          tick_s, wrap_s, blank_s, dark_s, on_s;
  logic [4:0]    column_n_s;
  logic [6:0]    row_s;

  assign tick_s = (cnt_q == CNT_LAST);
  assign wrap_s = tick_s && (idx_q == 3'd4);
  assign on_s   = reset_n && bus.enable && CFG_OK;

  generate
    if (BLANK == 0) begin : g_no_blank
      assign blank_s = 1'b0;
    end else begin : g_blank
      assign blank_s = (cnt_q < CW'(BLANK));
    end
  endgenerate

  // Prescaler, column index and frame-latched shadow image
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shadow_2_d = shadow_2_q;
    shadow_1_d = shadow_1_q;
    shadow_0_d = shadow_0_q;
    if (!bus.enable) begin
      cnt_d      = {CW{1'b0}};
      idx_d      = 3'd0;
      shadow_2_d = bus.col_2_in;
      shadow_1_d = bus.col_1_in;
      shadow_0_d = bus.col_0_in;
    end else if (tick_s) begin
      cnt_d = {CW{1'b0}};
      if (wrap_s) begin
        idx_d      = 3'd0;
        shadow_2_d = bus.col_2_in;
        shadow_1_d = bus.col_1_in;
        shadow_0_d = bus.col_0_in;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Scan state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= {CW{1'b0}};
      idx_q      <= 3'd0;
      shadow_2_q <= 7'h00;
      shadow_1_q <= 7'h00;
      shadow_0_q <= 7'h00;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_2_q <= shadow_2_d;
      shadow_1_q <= shadow_1_d;
      shadow_0_q <= shadow_0_d;
    end
  end

`ifdef LED_MATRIX_SCAN_BLINK_EN
  localparam int            FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Blink half-period frame counter and phase
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!bus.enable) begin
      frame_cnt_d   = {FW{1'b0}};
      blink_phase_d = 1'b0;
    end else if (wrap_s) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = {FW{1'b0}};
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Blink state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q   <= {FW{1'b0}};
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign dark_s = bus.blink && blink_phase_q;
`else
  assign dark_s = 1'b0;
`endif

  // Column select and mirrored row decode
  always_comb begin
    column_n_s = 5'b11111;
    row_s      = 7'h00;
    if (on_s && !blank_s && !dark_s) begin
      case (idx_q)
        3'd0:    begin column_n_s = 5'b11110; row_s = shadow_2_q; end
        3'd1:    begin column_n_s = 5'b11101; row_s = shadow_1_q; end
        3'd2:    begin column_n_s = 5'b11011; row_s = shadow_0_q; end
        3'd3:    begin column_n_s = 5'b10111; row_s = shadow_1_q; end
        3'd4:    begin column_n_s = 5'b01111; row_s = shadow_2_q; end
        default: begin column_n_s = 5'b11111; row_s = 7'h00;      end
      endcase
    end else begin
      column_n_s = 5'b11111;
      row_s      = 7'h00;
    end
  end

  assign bus.column_n    = column_n_s;
  assign bus.row         = row_s;
  assign bus.frame_start = on_s && (idx_q == 3'd0) && (cnt_q == {CW{1'b0}});

endmodule
